// File: rtl/nfsr_keystream_xor.sv
// nfsr_keystream_xor
//   Controller and consumer for the 24-bit nfsr keystream generator. It loads
//   a session seed into the nfsr, discards a fixed number of warm-up bits, and
//   then packs the serial keystream into WORD_W-bit words. Each keystream word
//   is XORed with exactly one plaintext word to produce one ciphertext word.
//   Plaintext input and ciphertext output both use a valid/ready handshake.
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous active-low reset (0 = reset)
//   start     begin a session (latch Seed_in); only honoured while idle
//   stop      end the session after the word currently in progress
//   Seed_in   session seed
//   Seed      registered seed driven to the nfsr
//   Par_load  nfsr parallel load strobe
//   shift_en  nfsr shift enable
//   Ser_in    serial keystream bit from the nfsr
//   pt_valid  plaintext word valid
//   pt_data   plaintext word
//   pt_ready  plaintext word accepted this cycle
//   ct_valid  ciphertext word valid
//   ct_data   ciphertext word (plaintext ^ keystream)
//   ct_ready  ciphertext sink ready
//   busy      high whenever a session is active

module nfsr_keystream_xor #(
  parameter int SEED_W = 24,
  parameter int WORD_W = 8,
  parameter int WARMUP = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [SEED_W-1:0] Seed_in,
  output logic [SEED_W-1:0] Seed,
  output logic              Par_load,
  output logic              shift_en,
  input  logic              Ser_in,
  input  logic              pt_valid,
  input  logic [WORD_W-1:0] pt_data,
  output logic              pt_ready,
  output logic              ct_valid,
  output logic [WORD_W-1:0] ct_data,
  input  logic              ct_ready,
  output logic              busy
);

  // One counter serves both the warm-up phase and the bit-gathering phase,
  // so it must be wide enough for whichever of the two is longer.
  localparam int CNT_MAX = (WARMUP > WORD_W) ? WARMUP : WORD_W;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  // WARMUP may be 0, in which case the warm-up state is never entered; the
  // guard only keeps the terminal-count constant non-negative.
  localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'((WARMUP > 0) ? WARMUP - 1 : 0);
  localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(WORD_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WARM,
    GATHER,
    READY,
    OUT
  } state_t;

  state_t            state;
  logic [WORD_W-1:0] ks;
  logic [CNT_W-1:0]  cnt;
  logic              stop_pend;

  // All control outputs are pure decodes of the registered state, so there is
  // no combinational path from any input to any output. Because LOAD and the
  // shifting states are distinct, shift_en can never coincide with Par_load,
  // and the nfsr stays frozen while a word waits in READY or OUT.
  assign Par_load = (state == LOAD);
  assign shift_en = (state == WARM) || (state == GATHER);
  assign pt_ready = (state == READY);
  assign ct_valid = (state == OUT);
  assign busy     = (state != IDLE);

  // Session sequencer. A stop seen in any active state is remembered in
  // stop_pend and only acted on when a word boundary is reached (leaving
  // READY without a plaintext word, or leaving OUT after the handshake), so a
  // word already being gathered always completes. The IDLE-entry branches
  // below are written after the latch so that the clear on entry wins.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      Seed      <= '0;
      ks        <= '0;
      ct_data   <= '0;
      cnt       <= '0;
      stop_pend <= 1'b0;
    end else begin
      if ((state != IDLE) && stop) begin
        stop_pend <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (start) begin
            Seed  <= Seed_in;
            state <= LOAD;
          end
        end

        LOAD: begin
          cnt   <= '0;
          state <= (WARMUP > 0) ? WARM : GATHER;
        end

        WARM: begin
          if (cnt == WARM_LAST) begin
            cnt   <= '0;
            state <= GATHER;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        // First bit gathered ends up in the MSB of the keystream word.
        GATHER: begin
          ks <= {ks[WORD_W-2:0], Ser_in};
          if (cnt == WORD_LAST) begin
            cnt   <= '0;
            state <= READY;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        // A plaintext word takes priority over stop; the stop then stays
        // pending and is honoured when the ciphertext leaves OUT.
        READY: begin
          if (pt_valid) begin
            ct_data <= pt_data ^ ks;
            state   <= OUT;
          end else if (stop || stop_pend) begin
            stop_pend <= 1'b0;
            state     <= IDLE;
          end
        end

        OUT: begin
          if (ct_ready) begin
            if (stop || stop_pend) begin
              stop_pend <= 1'b0;
              state     <= IDLE;
            end else begin
              state <= GATHER;
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nfsr_keystream_xor.sv
// tb_nfsr_keystream_xor
//   Self-checking bench for nfsr_keystream_xor. The nfsr is stood in for by a
//   queue of keystream bits: one bit is consumed for every cycle in which the
//   DUT asserts shift_en, and a fixed fill value is presented once the queue
//   runs dry. Expected ciphertext is the plaintext XOR the keystream word made
//   from the bits after the warm-up bits, taken WORD_W at a time, MSB first.

module tb_nfsr_keystream_xor;

  localparam int SEED_W = 24;
  localparam int WORD_W = 8;
  localparam int WARMUP = 24;
  localparam int NRAND  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              stop;
  logic [SEED_W-1:0] Seed_in;
  logic [SEED_W-1:0] Seed;
  logic              Par_load;
  logic              shift_en;
  logic              ser_in;
  logic              pt_valid;
  logic [WORD_W-1:0] pt_data;
  logic              pt_ready;
  logic              ct_valid;
  logic [WORD_W-1:0] ct_data;
  logic              ct_ready;
  logic              busy;

  int checks = 0;
  int errors = 0;

  bit   ser_q[$];
  logic ser_fill     = 1'b0;
  logic shift_seen   = 1'b0;
  logic overlap_seen = 1'b0;

  typedef struct {
    logic [WORD_W-1:0] ks;
    logic [WORD_W-1:0] pt;
    logic [WORD_W-1:0] ct;
  } vec_t;

  vec_t vecs[8];

  nfsr_keystream_xor #(
    .SEED_W(SEED_W),
    .WORD_W(WORD_W),
    .WARMUP(WARMUP)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .stop    (stop),
    .Seed_in (Seed_in),
    .Seed    (Seed),
    .Par_load(Par_load),
    .shift_en(shift_en),
    .Ser_in  (ser_in),
    .pt_valid(pt_valid),
    .pt_data (pt_data),
    .pt_ready(pt_ready),
    .ct_valid(ct_valid),
    .ct_data (ct_data),
    .ct_ready(ct_ready),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  // Sample the nfsr controls mid-cycle, well away from the active edge.
  always @(negedge clk) begin
    shift_seen = shift_en;
    if (shift_en && Par_load) overlap_seen = 1'b1;
  end

  // Keystream source: a bit is used up at each edge where shift_en was high.
  initial begin
    ser_in = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (shift_seen && ser_q.size() > 0) void'(ser_q.pop_front());
      ser_in = (ser_q.size() > 0) ? ser_q[0] : ser_fill;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic pushWord(input logic [WORD_W-1:0] w);
    for (int i = WORD_W - 1; i >= 0; i--) ser_q.push_back(w[i]);
  endtask

  task automatic pushWarmup;
    for (int i = 0; i < WARMUP; i++) ser_q.push_back(1'($urandom_range(1, 0)));
  endtask

  task automatic startSession(input logic [SEED_W-1:0] seed);
    Seed_in = seed;
    start   = 1'b1;
    tick;
    start   = 1'b0;
  endtask

  task automatic waitReady(input string name);
    int n = 0;
    while (!pt_ready && n < 200) begin
      tick;
      n++;
    end
    if (!pt_ready) checkOutput({name, "_timeout"}, 32'(pt_ready), 1);
  endtask

  // One full word transaction: offer plaintext in READY, take the ciphertext.
  task automatic applyStimulus(input logic [WORD_W-1:0] pt, output logic [WORD_W-1:0] ct);
    waitReady("pt_ready");
    pt_valid = 1'b1;
    pt_data  = pt;
    tick;
    pt_valid = 1'b0;
    checkOutput("ct_valid_after_accept", 32'(ct_valid), 1);
    ct       = ct_data;
    ct_ready = 1'b1;
    tick;
    ct_ready = 1'b0;
  endtask

  task automatic endSession;
    waitReady("end_ready");
    stop = 1'b1;
    tick;
    stop = 1'b0;
    checkOutput("busy_after_stop", 32'(busy), 0);
  endtask

  initial begin
    logic [WORD_W-1:0] got;
    logic [WORD_W-1:0] rks[NRAND];
    logic [WORD_W-1:0] rpt[NRAND];
    int n;
    int bad;
    int in_idx;
    int out_idx;
    int stamp[3];
    bit acc;
    bit cons;
    logic [WORD_W-1:0] cd;

    vecs[0] = '{ks: 8'h00, pt: 8'h00, ct: 8'h00};
    vecs[1] = '{ks: 8'h00, pt: 8'h3C, ct: 8'h3C};
    vecs[2] = '{ks: 8'h00, pt: 8'hFF, ct: 8'hFF};
    vecs[3] = '{ks: 8'hAA, pt: 8'hFF, ct: 8'h55};
    vecs[4] = '{ks: 8'hFF, pt: 8'h5A, ct: 8'hA5};
    vecs[5] = '{ks: 8'h0F, pt: 8'hF0, ct: 8'hFF};
    vecs[6] = '{ks: 8'h12, pt: 8'h34, ct: 8'h26};
    vecs[7] = '{ks: 8'hC3, pt: 8'h5A, ct: 8'h99};

    rst = 1'b0; start = 1'b0; stop = 1'b0; Seed_in = '0;
    pt_valid = 1'b0; pt_data = '0; ct_ready = 1'b0;
    tick;
    tick;
    checkOutput("rst_seed", 32'(Seed), 0);
    checkOutput("rst_par_load", 32'(Par_load), 0);
    checkOutput("rst_shift_en", 32'(shift_en), 0);
    checkOutput("rst_pt_ready", 32'(pt_ready), 0);
    checkOutput("rst_ct_valid", 32'(ct_valid), 0);
    checkOutput("rst_ct_data", 32'(ct_data), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    rst = 1'b1;
    tick;

    $display("[TB] Ser_in tied 1, seed load, warm-up and first word");
    ser_q.delete();
    ser_fill = 1'b1;
    tick;
    startSession(24'habcdef);
    checkOutput("t1_par_load", 32'(Par_load), 1);
    checkOutput("t1_no_shift_in_load", 32'(shift_en), 0);
    checkOutput("t1_busy", 32'(busy), 1);
    tick;
    n = 0;
    while (shift_en && n < 100) begin
      n++;
      tick;
    end
    checkOutput("t1_shift_cycles", 32'(n), WARMUP + WORD_W);
    checkOutput("t1_par_load_once", 32'(Par_load), 0);
    checkOutput("t1_pt_ready", 32'(pt_ready), 1);
    checkOutput("t1_seed", 32'(Seed), 'habcdef);
    pt_valid = 1'b1;
    pt_data  = 8'h5A;
    stop     = 1'b1;
    tick;
    pt_valid = 1'b0;
    stop     = 1'b0;
    checkOutput("t1_ct_valid", 32'(ct_valid), 1);
    checkOutput("t1_ct_data", 32'(ct_data), 'hA5);
    ct_ready = 1'b1;
    tick;
    ct_ready = 1'b0;
    checkOutput("t1_idle_after_stop", 32'(busy), 0);

    $display("[TB] table-driven word stream in one session");
    ser_q.delete();
    ser_fill = 1'b0;
    pushWarmup();
    for (int i = 0; i < 8; i++) pushWord(vecs[i].ks);
    tick;
    startSession(24'h13579b);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].pt, got);
      checkOutput($sformatf("vec%0d_ct", i), 32'(got), 32'(vecs[i].ct));
    end
    endSession();

    $display("[TB] ciphertext stall in OUT");
    ser_q.delete();
    pushWarmup();
    pushWord(8'h6B);
    pushWord(8'h94);
    tick;
    startSession(24'h0badf0);
    waitReady("t4_ready");
    pt_valid = 1'b1;
    pt_data  = 8'h11;
    tick;
    pt_valid = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (ct_valid !== 1'b1 || ct_data !== 8'h7A || shift_en !== 1'b0) bad++;
      tick;
    end
    checkOutput("t4_stall_stable", 32'(bad), 0);
    ct_ready = 1'b1;
    tick;
    ct_ready = 1'b0;
    checkOutput("t4_resume_gather", 32'(shift_en), 1);
    applyStimulus(8'h22, got);
    checkOutput("t4_next_word", 32'(got), 'hB6);
    endSession();

    $display("[TB] stop during GATHER");
    ser_q.delete();
    pushWarmup();
    pushWord(8'h3E);
    pushWord(8'h77);
    tick;
    startSession(24'h445566);
    applyStimulus(8'h01, got);
    checkOutput("t5_first_word", 32'(got), 'h3F);
    stop = 1'b1;
    tick;
    stop = 1'b0;
    pt_valid = 1'b1;
    pt_data  = 8'h80;
    n = 0;
    while (!ct_valid && n < 50) begin
      tick;
      n++;
    end
    pt_valid = 1'b0;
    checkOutput("t5_ct_valid", 32'(ct_valid), 1);
    checkOutput("t5_ct_data", 32'(ct_data), 'hF7);
    ct_ready = 1'b1;
    tick;
    ct_ready = 1'b0;
    checkOutput("t5_idle_busy", 32'(busy), 0);
    checkOutput("t5_idle_pt_ready", 32'(pt_ready), 0);
    startSession(24'h778899);
    checkOutput("t5_restart_par_load", 32'(Par_load), 1);

    $display("[TB] reset mid-WARM and mid-OUT");
    for (int i = 0; i < 5; i++) tick;
    rst = 1'b0;
    tick;
    checkOutput("t6w_busy", 32'(busy), 0);
    checkOutput("t6w_shift_en", 32'(shift_en), 0);
    checkOutput("t6w_seed", 32'(Seed), 0);
    tick;
    rst = 1'b1;
    tick;
    ser_q.delete();
    tick;
    startSession(24'h246802);
    waitReady("t6_ready");
    pt_valid = 1'b1;
    pt_data  = 8'hC4;
    tick;
    pt_valid = 1'b0;
    checkOutput("t6o_in_out", 32'(ct_valid), 1);
    rst = 1'b0;
    tick;
    checkOutput("t6o_ct_valid", 32'(ct_valid), 0);
    checkOutput("t6o_ct_data", 32'(ct_data), 0);
    checkOutput("t6o_busy", 32'(busy), 0);
    tick;
    rst = 1'b1;
    tick;
    startSession(24'h123456);
    tick;
    tick;
    startSession(24'h654321);
    checkOutput("t6_busy_start_seed", 32'(Seed), 'h123456);
    checkOutput("t6_busy_start_no_load", 32'(Par_load), 0);
    rst = 1'b0;
    tick;
    tick;
    rst = 1'b1;
    tick;

    $display("[TB] randomized handshakes against keystream model");
    ser_q.delete();
    ser_fill = 1'b0;
    pushWarmup();
    for (int i = 0; i < NRAND; i++) begin
      rks[i] = WORD_W'($urandom);
      rpt[i] = WORD_W'($urandom);
      pushWord(rks[i]);
    end
    tick;
    startSession(SEED_W'($urandom));
    in_idx  = 0;
    out_idx = 0;
    n = 0;
    while (out_idx < NRAND && n < 3000) begin
      pt_valid = (in_idx < NRAND) ? 1'($urandom_range(1, 0)) : 1'b0;
      pt_data  = (in_idx < NRAND) ? rpt[in_idx] : '0;
      ct_ready = 1'($urandom_range(1, 0));
      acc  = pt_valid && pt_ready;
      cons = ct_valid && ct_ready;
      cd   = ct_data;
      tick;
      if (acc) in_idx++;
      if (cons) begin
        checkOutput($sformatf("rand%0d_ct", out_idx), 32'(cd), 32'(rpt[out_idx] ^ rks[out_idx]));
        out_idx++;
      end
      n++;
    end
    pt_valid = 1'b0;
    ct_ready = 1'b0;
    checkOutput("rand_words_out", 32'(out_idx), NRAND);
    endSession();

    $display("[TB] throughput with both sides always ready");
    ser_q.delete();
    ser_fill = 1'b1;
    tick;
    startSession(24'h00ff00);
    pt_valid = 1'b1;
    pt_data  = 8'h0F;
    ct_ready = 1'b1;
    out_idx = 0;
    bad = 0;
    n = 0;
    while (out_idx < 3 && n < 200) begin
      if (ct_valid) begin
        stamp[out_idx] = n;
        if (ct_data !== 8'hF0) bad++;
        out_idx++;
      end
      tick;
      n++;
    end
    checkOutput("tp_words", 32'(out_idx), 3);
    checkOutput("tp_data", 32'(bad), 0);
    if (out_idx == 3) begin
      checkOutput("tp_period_a", 32'(stamp[1] - stamp[0]), WORD_W + 2);
      checkOutput("tp_period_b", 32'(stamp[2] - stamp[1]), WORD_W + 2);
    end
    stop = 1'b1;
    n = 0;
    while (busy && n < 50) begin
      tick;
      n++;
    end
    stop     = 1'b0;
    pt_valid = 1'b0;
    ct_ready = 1'b0;
    checkOutput("tp_stop_idle", 32'(busy), 0);

    checkOutput("no_shift_during_load", 32'(overlap_seen), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
